// File: rtl/fp_calc_ctrl.sv
// ============================================================================
//  Module   : fp_calc_ctrl (with fp_add_sub, fp_div)
//  Brief    : Request/response front-end dispatching binary64 add/sub/div.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Combinational binary64 add/sub: normal and zero operands, truncating.
module fp_add_sub (
    input  logic [63:0] fp_a_in,
    input  logic [63:0] fp_b_in,
    input  logic        is_sub,
    output logic [63:0] fp_res_out
);
    logic [63:0] big_op, sml_op;
    logic        sign_b, swap, eff_sub;
    logic [10:0] e_big, e_sml, shamt;
    logic [56:0] m_big, m_sml, m_sum, m_norm;
    logic [5:0]  lz;
    logic [12:0] e_res;

    always_comb begin
        sign_b  = fp_b_in[63] ^ is_sub;
        swap    = fp_b_in[62:0] > fp_a_in[62:0];
        big_op  = swap ? {sign_b, fp_b_in[62:0]} : fp_a_in;
        sml_op  = swap ? fp_a_in : {sign_b, fp_b_in[62:0]};
        e_big   = big_op[62:52];
        e_sml   = sml_op[62:52];
        m_big   = {1'b0, |e_big, big_op[51:0], 3'b000};
        m_sml   = {1'b0, |e_sml, sml_op[51:0], 3'b000};
        shamt   = e_big - e_sml;
        m_sml   = (shamt > 11'd56) ? '0 : (m_sml >> shamt);
        eff_sub = big_op[63] ^ sml_op[63];
        m_sum   = eff_sub ? (m_big - m_sml) : (m_big + m_sml);
        lz      = '0;
        for (int i = 0; i <= 55; i++) begin
            if (m_sum[i]) lz = 6'(55 - i);
        end
        if (m_sum[56]) begin
            m_norm = m_sum >> 1;
            e_res  = {2'b00, e_big} + 13'd1;
        end else begin
            m_norm = m_sum << lz;
            e_res  = {2'b00, e_big} - {7'd0, lz};
        end
        // Exponent below 1 flushes to zero, above 2046 saturates to infinity.
        if (m_sum == '0)
            fp_res_out = 64'd0;
        else if (e_res[12] || e_res == 13'd0)
            fp_res_out = {big_op[63], 63'd0};
        else if (e_res >= 13'd2047)
            fp_res_out = {big_op[63], 11'h7FF, 52'd0};
        else
            fp_res_out = {big_op[63], e_res[10:0], m_norm[54:3]};
    end
endmodule

// Multi-cycle binary64 divider: restoring mantissa division, one bit per cycle.
module fp_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] fp_a_in,
    input  logic [63:0] fp_b_in,
    output logic [63:0] fp_res_out,
    output logic        done
);
    logic [53:0] rem_q, rem_d, rem_sub, div_m;
    logic [54:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [12:0] exp_w;
    logic [51:0] frac_w;
    logic        sign_w;

    assign div_m = {1'b0, |fp_b_in[62:52], fp_b_in[51:0]};
    assign done  = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rem_sub = rem_q - div_m;
        if (start) begin
            rem_d  = {1'b0, |fp_a_in[62:52], fp_a_in[51:0]};
            quo_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (rem_q >= div_m) begin
                quo_d = {quo_q[53:0], 1'b1};
                rem_d = {rem_sub[52:0], 1'b0};
            end else begin
                quo_d = {quo_q[53:0], 1'b0};
                rem_d = {rem_q[52:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd54) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // quo_q[54] is the integer bit; the quotient lies in (0.5, 2).
    always_comb begin
        sign_w = fp_a_in[63] ^ fp_b_in[63];
        if (quo_q[54]) begin
            exp_w  = {2'b00, fp_a_in[62:52]} - {2'b00, fp_b_in[62:52]} + 13'd1023;
            frac_w = quo_q[53:2];
        end else begin
            exp_w  = {2'b00, fp_a_in[62:52]} - {2'b00, fp_b_in[62:52]} + 13'd1022;
            frac_w = quo_q[52:1];
        end
        if (fp_a_in[62:52] == 11'd0)
            fp_res_out = {sign_w, 63'd0};
        else if (fp_b_in[62:52] == 11'd0 || (!exp_w[12] && exp_w >= 13'd2047))
            fp_res_out = {sign_w, 11'h7FF, 52'd0};
        else if (exp_w[12] || exp_w == 13'd0)
            fp_res_out = {sign_w, 63'd0};
        else
            fp_res_out = {sign_w, exp_w[10:0], frac_w};
    end
endmodule

module fp_calc_ctrl #(
    parameter int DIV_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err
);
    localparam logic [2:0]  c_idle      = 3'd0;
    localparam logic [2:0]  c_add       = 3'd1;
    localparam logic [2:0]  c_div_start = 3'd2;
    localparam logic [2:0]  c_div_wait  = 3'd3;
    localparam logic [2:0]  c_resp      = 3'd4;
    localparam logic [63:0] c_qnan      = 64'h7FF8000000000000;
    localparam logic [15:0] c_cnt_last  = 16'(DIV_TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        is_sub, div_start, div_done;
    logic [63:0] add_res, div_res;

    assign is_sub   = (op_q == 2'b01);
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

    fp_add_sub u_add (
        .fp_a_in    (a_q),
        .fp_b_in    (b_q),
        .is_sub     (is_sub),
        .fp_res_out (add_res)
    );

    fp_div u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (div_start),
        .fp_a_in    (a_q),
        .fp_b_in    (b_q),
        .fp_res_out (div_res),
        .done       (div_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= c_idle;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        case (state_q)
            c_idle: begin
                if (req_valid && req_ready) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    case (req_op)
                        2'b00, 2'b01: state_d = c_add;
                        2'b10:        state_d = c_div_start;
                        default: begin
                            rsp_data_d = c_qnan;
                            rsp_err_d  = 1'b1;
                            state_d    = c_resp;
                        end
                    endcase
                end
            end
            c_add: begin
                rsp_data_d = add_res;
                rsp_err_d  = 1'b0;
                state_d    = c_resp;
            end
            c_div_start: begin
                cnt_d   = '0;
                state_d = c_div_wait;
            end
            c_div_wait: begin
                cnt_d = cnt_q + 16'd1;
                // A completion in the timeout cycle still delivers the quotient.
                if (div_done) begin
                    rsp_data_d = div_res;
                    rsp_err_d  = 1'b0;
                    state_d    = c_resp;
                end else if (cnt_q == c_cnt_last) begin
                    rsp_data_d = c_qnan;
                    rsp_err_d  = 1'b1;
                    state_d    = c_resp;
                end
            end
            c_resp: begin
                if (rsp_ready) state_d = c_idle;
            end
            default: state_d = c_idle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == c_idle);
        rsp_valid = (state_q == c_resp);
        div_start = (state_q == c_div_start);
    end
endmodule

`default_nettype wire
